uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: DATA_BITS, default 8, number of data bits per frame (5..8).
REQ-002 Parameter: OVS_FACTOR, default 16, tick_16x pulses per bit period (even, 4..16).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 tick_16x  input  1  one-clk oversample strobe from the baud generator.
REQ-006 rx  input  1  asynchronous serial line; idle high.
REQ-007 data_out  output  DATA_BITS  last received data word.
REQ-008 data_valid  output  1  data_out holds an unconsumed word.
REQ-009 data_ready  input  1  consumer accepts data_out in the current cycle.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 frame_err  output  1  one-clk pulse when the stop bit is sampled low.
REQ-012 overrun_err  output  1  one-clk pulse when an unconsumed word is overwritten.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer (rx_s); both flops reset to 1; all sampling uses rx_s.
REQ-014 State, counter and sampling logic SHALL advance only on cycles with tick_16x=1; on all other cycles they hold.
REQ-015 The FSM SHALL have states IDLE, START, DATA and STOP.
REQ-016 An armed flag SHALL be set on any tick with rx_s=1 and cleared on entry to START; it resets to 0.
REQ-017 In IDLE, a tick with armed=1 and rx_s=0 SHALL enter START with ovs_cnt=0; this is tick 0.
REQ-018 ovs_cnt SHALL be $clog2(OVS_FACTOR) bits wide, increment on each tick in START/DATA/STOP, and clear on every sample point.
REQ-019 START: on the tick where ovs_cnt==OVS_FACTOR/2-1 (tick 8 at default), rx_s=1 SHALL return to IDLE with no outputs; rx_s=0 SHALL enter DATA with bit_cnt=0.
REQ-020 DATA: on the tick where ovs_cnt==OVS_FACTOR-1, rx_s SHALL be shifted in LSB-first and bit_cnt incremented; after the DATA_BITS-th sample the FSM SHALL enter STOP.
REQ-021 At default parameters, data bit k SHALL be sampled at tick 24+16k, and the stop bit at tick 152.
REQ-022 STOP with rx_s=1 at ovs_cnt==OVS_FACTOR-1: data_out SHALL load the shift register and data_valid SHALL be 1 on the next cycle; then return to IDLE.
REQ-023 STOP with rx_s=0: frame_err SHALL pulse for one clk, data_out and data_valid SHALL be unchanged, and the FSM returns to IDLE with armed=0.
REQ-024 data_valid SHALL clear on the cycle after a cycle with data_valid=1 and data_ready=1.
REQ-025 If a new word loads while data_valid=1 and data_ready=0: data_out SHALL be overwritten, overrun_err SHALL pulse for one clk, and data_valid SHALL stay 1.
REQ-026 If a new word loads in the same cycle as data_valid=1 and data_ready=1: data_valid SHALL stay 1, data_out takes the new word, and overrun_err SHALL stay 0.
REQ-027 busy SHALL be registered, equal to (state!=IDLE), and fall on the cycle after the return to IDLE.

Reset
REQ-028 reset_n=0 SHALL immediately force state=IDLE, ovs_cnt=0, bit_cnt=0, the shift register to 0, data_out=0, data_valid=0, busy=0, frame_err=0, overrun_err=0, armed=0 and the synchronizer flops to 1.
REQ-029 Reset asserted mid-frame SHALL abandon the frame; after release, reception restarts only after rx_s=1 is seen on a tick and a new falling edge follows.

Verification
REQ-030 Scenario: 16 ticks/bit, frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop), data_ready=0 -> data_out=0xA5, data_valid=1 after tick 152, busy=0 afterward.
REQ-031 Scenario: rx low for 4 ticks then high -> START rejects at tick 8, busy falls, data_valid=0, frame_err=0.
REQ-032 Scenario: frame 0x5A with stop bit held low -> frame_err single pulse, data_valid=0; no new start until rx returns high.
REQ-033 Scenario: frames 0x3C then 0xC3 with data_ready=0 -> overrun_err one pulse at the second load, data_out=0xC3, data_valid=1.
REQ-034 Scenario: data_ready pulsed in the same cycle as the second load -> data_out=0xC3, data_valid=1, overrun_err=0.
REQ-035 Scenario: reset_n low at tick 60 of frame 0xFF -> all outputs 0 immediately; a following clean 0x81 frame is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, oversampled start/data/stop
// sampling driven by an external tick strobe, one-word output holding register
// with valid/ready handshake, and frame/overrun error pulses.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVS_FACTOR = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tick_16x,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun_err
);

  localparam int OW = $clog2(OVS_FACTOR);
  localparam int BW = $clog2(DATA_BITS) + 1;
  localparam logic [OW-1:0] C_HALF = OW'(OVS_FACTOR / 2 - 1);
  localparam logic [OW-1:0] C_FULL = OW'(OVS_FACTOR - 1);
  localparam logic [BW-1:0] C_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic                 r_rx_meta;
  logic                 r_rx_s;
  state_t               r_state;
  logic [OW-1:0]        r_ovs_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data_out;
  logic                 r_data_valid;
  logic                 r_busy;
  logic                 r_frame_err;
  logic                 r_overrun_err;
  logic                 r_armed;

  assign data_out    = r_data_out;
  assign data_valid  = r_data_valid;
  assign busy        = r_busy;
  assign frame_err   = r_frame_err;
  assign overrun_err = r_overrun_err;

  // Two-flop synchronizer; idles high so reset never looks like a start edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Receive FSM, sample counters, holding register and error pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_ovs_cnt     <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_data_out    <= '0;
      r_data_valid  <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
      r_armed       <= 1'b0;
    end else begin
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
      r_busy        <= (r_state != S_IDLE);
      if (r_data_valid && data_ready) begin
        r_data_valid <= 1'b0;
      end
      if (tick_16x) begin
        // A high line must be seen before a falling edge counts as a start
        if (r_rx_s) begin
          r_armed <= 1'b1;
        end
        case (r_state)
          S_IDLE: begin
            if (r_armed && !r_rx_s) begin
              r_state   <= S_START;
              r_ovs_cnt <= '0;
              r_armed   <= 1'b0;
            end
          end
          S_START: begin
            if (r_ovs_cnt == C_HALF) begin
              r_ovs_cnt <= '0;
              if (r_rx_s) begin
                r_state <= S_IDLE;
              end else begin
                r_state   <= S_DATA;
                r_bit_cnt <= '0;
              end
            end else begin
              r_ovs_cnt <= r_ovs_cnt + 1'b1;
            end
          end
          S_DATA: begin
            if (r_ovs_cnt == C_FULL) begin
              r_ovs_cnt <= '0;
              r_shift   <= {r_rx_s, r_shift[DATA_BITS-1:1]};
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == C_LAST) begin
                r_state <= S_STOP;
              end
            end else begin
              r_ovs_cnt <= r_ovs_cnt + 1'b1;
            end
          end
          S_STOP: begin
            if (r_ovs_cnt == C_FULL) begin
              r_ovs_cnt <= '0;
              r_state   <= S_IDLE;
              if (r_rx_s) begin
                // Same-cycle consume frees the slot, so no overrun then
                r_data_out    <= r_shift;
                r_data_valid  <= 1'b1;
                r_overrun_err <= r_data_valid && !data_ready;
              end else begin
                // Line stuck low: require it to go high again before re-arming
                r_frame_err <= 1'b1;
                r_armed     <= 1'b0;
              end
            end else begin
              r_ovs_cnt <= r_ovs_cnt + 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
